dotp_seq_ctrl: RTL and testbench
================================

# dotp_seq_ctrl

Sequencer that drives the four-register multiply datapath (R0–R3, `sel`/`load`/`data` control) to compute a dot product of two LEN-element 8-bit vectors. For each element pair it issues load-R1, load-R2 and multiply-into-R3 steps, then accumulates R3 into an internal result register. It sits between a streaming element source and the datapath, replacing hand-written `sel`/`load` sequences.

## Interface
Parameters:
- `LEN`, 4, number of element pairs per dot product (≥1)
- `ACC_W`, 12, accumulator/result width (≥8)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin new dot product; sampled only in IDLE
- `in_valid`  in  1  element pair available
- `in_a`  in  8  element of vector A
- `in_b`  in  8  element of vector B
- `in_ready`  out  1  controller accepts a pair this cycle
- `dp_sel`  out  3  datapath mux select (4 = external data, 3 = R1*R2)
- `dp_load`  out  4  datapath one-hot register load enables {R3,R2,R1,R0}
- `dp_data`  out  8  datapath external data
- `dp_r3`  in  8  datapath R3 value
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse, result valid
- `result`  out  ACC_W  dot product, held until next `start`

## Operation
- States: IDLE, WAIT_IN, LOAD_A, LOAD_B, MUL, ACC, DONE.
- IDLE: `dp_load`=0, `dp_sel`=0, `dp_data`=0. On `start`: clear accumulator and element count, → WAIT_IN. `result` keeps previous value until cleared by `start`.
- WAIT_IN: `in_ready`=1. On `in_valid`: latch `in_a`/`in_b` into a_q/b_q, → LOAD_A. Otherwise stay.
- LOAD_A: `dp_sel`=4, `dp_load`=0010, `dp_data`=a_q → LOAD_B.
- LOAD_B: `dp_sel`=4, `dp_load`=0100, `dp_data`=b_q → MUL.
- MUL: `dp_sel`=3, `dp_load`=1000 → ACC.
- ACC: `dp_load`=0; acc ← acc + zero-extended `dp_r3` (mod 2^ACC_W); count+1. If count was LEN-1 → DONE, else → WAIT_IN.
- DONE: `done`=1, `result` ← acc already final, → IDLE.
- `in_ready` is 0 in every state except WAIT_IN; `start` outside IDLE is ignored.
- In every state other than LOAD_A/LOAD_B/MUL, `dp_load`=0000, `dp_data`=0.
- `result` is updated on the ACC→DONE edge only; accumulator overflow wraps silently.

## Timing
- Reset (async, any state, mid-sequence included): state=IDLE, count=0, acc=0, `result`=0, `in_ready`=0, `busy`=0, `done`=0, `dp_sel`=0, `dp_load`=0, `dp_data`=0.
- `start` at edge k → WAIT_IN at k+1.
- With `in_valid` held high: 5 cycles per pair (WAIT_IN, LOAD_A, LOAD_B, MUL, ACC); `done` high in cycle 5·LEN+1 after `start` edge; back in IDLE one cycle later.
- Stall: each cycle `in_valid`=0 in WAIT_IN adds one cycle; nothing else stalls.
- `start` asserted in the same cycle as `done` is ignored (not IDLE).
- LEN=1: one pass, then DONE.

## Configuration
- `DOTP_ZERO_SKIP_EN` defined: at acceptance, if `in_a`==0 or `in_b`==0, go WAIT_IN → ACC directly, adding 0 instead of `dp_r3`; no datapath loads issued for that pair (2 cycles for the pair).
- Undefined: every pair takes the full LOAD_A/LOAD_B/MUL/ACC path regardless of value.

## Test plan
- Basic (bench instantiates the datapath): LEN=4, A={2,5,8,1}, B={5,3,10,7}, `in_valid` always high → `dp_load` sequence 0010,0100,1000 per pair, `done` at cycle 21 after start, `result`=112.
- Wrap: ACC_W=8, A=B={15,15,15,15} → `result`=132 (900 mod 256).
- Backpressure: `in_valid` low for 3 cycles before pair 2 → `in_ready` stays high, `done` 3 cycles later, `result` unchanged (112).
- Reset mid-run: assert `rst` during MUL of pair 3 → all outputs 0 immediately; new `start` with basic vectors → `result`=112.
- Ignored start: pulse `start` during LOAD_B and in the DONE cycle → no restart, single `done`, `result`=112.
- Zero skip: A={0,5,8,1}, B={5,3,0,7} → `result`=22; with `DOTP_ZERO_SKIP_EN` no `dp_load` activity for pairs 0 and 2, `done` 6 cycles earlier than without.

Source files
------------

// File: rtl/dotp_seq_ctrl_if.sv
// Handshake and datapath-control bundle for the dot-product sequencer.
// master = sequencer side, slave = element source / datapath side.
interface dotp_seq_ctrl_if #(
  parameter int ACC_W = 12
);
  logic             start;
  logic             in_valid;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             in_ready;
  logic [2:0]       dp_sel;
  logic [3:0]       dp_load;
  logic [7:0]       dp_data;
  logic [7:0]       dp_r3;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] result;

  modport master (
    input  start, in_valid, in_a, in_b, dp_r3,
    output in_ready, dp_sel, dp_load, dp_data,
    output busy, done, result
  );

  modport slave (
    output start, in_valid, in_a, in_b, dp_r3,
    input  in_ready, dp_sel, dp_load, dp_data,
    input  busy, done, result
  );
endinterface

// File: rtl/dotp_seq_ctrl.sv
// Dot-product sequencer for the four-register multiply datapath.
// Optional DOTP_ZERO_SKIP_EN: pairs with a zero operand bypass the datapath.
module dotp_seq_ctrl #(
  parameter int LEN   = 4,
  parameter int ACC_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  dotp_seq_ctrl_if.master bus
);
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_IN, LOAD_A, LOAD_B, MUL, ACC, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic [ACC_W-1:0] acc_sum;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic             skip_q, skip_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       sel_q, sel_d;
  logic [3:0]       load_q, load_d;
  logic [7:0]       data_q, data_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    skip_d  = skip_q;
    acc_sum = acc_q + (skip_q ? '0 : ACC_W'(bus.dp_r3));

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          cnt_d   = '0;
          res_d   = '0;
          state_d = WAIT_IN;
        end
      end
      WAIT_IN: begin
        if (bus.in_valid) begin
          a_d = bus.in_a;
          b_d = bus.in_b;
`ifdef DOTP_ZERO_SKIP_EN
          skip_d = (bus.in_a == 8'd0) ||
                   (bus.in_b == 8'd0);
`else
          skip_d = 1'b0;
`endif
          state_d = skip_d ? ACC : LOAD_A;
        end
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: state_d = MUL;
      MUL:    state_d = ACC;
      ACC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(LEN - 1)) begin
          res_d   = acc_sum;
          state_d = DONE;
        end else begin
          state_d = WAIT_IN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    rdy_d  = (state_d == WAIT_IN);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    sel_d  = 3'd0;
    load_d = 4'b0000;
    data_d = 8'd0;
    unique case (1'b1)
      (state_d == LOAD_A): begin
        sel_d  = 3'd4;
        load_d = 4'b0010;
        data_d = a_d;
      end
      (state_d == LOAD_B): begin
        sel_d  = 3'd4;
        load_d = 4'b0100;
        data_d = b_d;
      end
      (state_d == MUL): begin
        sel_d  = 3'd3;
        load_d = 4'b1000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      skip_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 3'd0;
      load_q  <= 4'b0000;
      data_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      skip_q  <= skip_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready = rdy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dp_sel   = sel_q;
  assign bus.dp_load  = load_q;
  assign bus.dp_data  = data_q;
  assign bus.result   = res_q;
endmodule

// File: tb/tb_dotp_seq_ctrl.sv
// Directed bench: two sequencers (ACC_W 12 and 8) each driving a
// behavioural four-register datapath, fed from a shared vector table.
module tb_dotp_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = 8'd0;
  logic [7:0] in_b = 8'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dotp_seq_ctrl_if #(.ACC_W(12)) i12 ();
  dotp_seq_ctrl_if #(.ACC_W(8))  i8 ();

  assign i12.start    = start;
  assign i12.in_valid = in_valid;
  assign i12.in_a     = in_a;
  assign i12.in_b     = in_b;
  assign i8.start     = start;
  assign i8.in_valid  = in_valid;
  assign i8.in_a      = in_a;
  assign i8.in_b      = in_b;

  dotp_seq_ctrl #(.LEN(4), .ACC_W(12)) u12 (
    .clk(clk), .rst(rst), .bus(i12)
  );
  dotp_seq_ctrl #(.LEN(4), .ACC_W(8)) u8 (
    .clk(clk), .rst(rst), .bus(i8)
  );

  function automatic logic [7:0] dp_mux(
    input logic [2:0] s, input logic [7:0] d,
    input logic [7:0] r0, input logic [7:0] r1,
    input logic [7:0] r2, input logic [7:0] r3
  );
    logic [15:0] p;
    p = r1 * r2;
    case (s)
      3'd0: return r0;
      3'd1: return r1;
      3'd2: return r2;
      3'd3: return p[7:0];
      3'd4: return d;
      default: return 8'd0;
    endcase
    return r3;
  endfunction

  logic [7:0] ra [4];
  logic [7:0] rb [4];
  logic [7:0] ma, mb;
  assign ma = dp_mux(i12.dp_sel, i12.dp_data,
                     ra[0], ra[1], ra[2], ra[3]);
  assign mb = dp_mux(i8.dp_sel, i8.dp_data,
                     rb[0], rb[1], rb[2], rb[3]);
  assign i12.dp_r3 = ra[3];
  assign i8.dp_r3  = rb[3];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i12.dp_load[i]) ra[i] <= ma;
      if (i8.dp_load[i])  rb[i] <= mb;
    end
  end

  typedef struct {
    string          nm;
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    int             stall_pair;
    int             stall_n;
    bit             noise;
    int             exp12;
    int             exp8;
    int             exp_done;
    int             exp_loads;
  } vec_t;

  vec_t tv [5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pat(input int k);
    case (k)
      0: return 4'b0010;
      1: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic chk_zero(input string nm);
    chk({nm, " in_ready"}, 32'(i12.in_ready), 0);
    chk({nm, " busy"},     32'(i12.busy), 0);
    chk({nm, " done"},     32'(i12.done), 0);
    chk({nm, " dp_sel"},   32'(i12.dp_sel), 0);
    chk({nm, " dp_load"},  32'(i12.dp_load), 0);
    chk({nm, " dp_data"},  32'(i12.dp_data), 0);
    chk({nm, " result"},   32'(i12.result), 0);
    chk({nm, " result8"},  32'(i8.result), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, pi, stall, loads, rdys;
    bit got;
    start = 1'b1;
    in_valid = 1'b1;
    in_a = v.a[0];
    in_b = v.b[0];
    tick();
    start = 1'b0;
    chk({v.nm, " busy after start"}, 32'(i12.busy), 1);
    cyc = 1; pi = 0; stall = v.stall_n;
    loads = 0; rdys = 0; got = 1'b0;
    while (cyc <= 200 && !got) begin
      if (i12.dp_load != 4'b0000) begin
        chk({v.nm, " dp_load order"},
            32'(i12.dp_load), 32'(pat(loads % 3)));
        loads++;
      end
      if (i12.done) begin
        got = 1'b1;
      end else begin
        if (v.noise && i12.dp_load == 4'b0100)
          start = 1'b1;
        if (pi < 4) begin
          in_a = v.a[pi];
          in_b = v.b[pi];
          in_valid = !(pi == v.stall_pair && stall > 0);
        end else begin
          in_valid = 1'b0;
        end
        if (i12.in_ready) begin
          rdys++;
          if (!in_valid) stall--;
          else pi++;
        end
        tick();
        start = 1'b0;
        cyc++;
      end
    end
    if (!got) begin
      chk({v.nm, " done timeout"}, 0, 1);
    end else begin
      chk({v.nm, " done cycle"}, 32'(cyc), 32'(v.exp_done));
      chk({v.nm, " ready cycles"}, 32'(rdys),
          32'(4 + v.stall_n));
      chk({v.nm, " load count"}, 32'(loads), 32'(v.exp_loads));
      chk({v.nm, " result12"}, 32'(i12.result), 32'(v.exp12));
      chk({v.nm, " done8"}, 32'(i8.done), 1);
      chk({v.nm, " result8"}, 32'(i8.result), 32'(v.exp8));
      if (v.noise) start = 1'b1;
      tick();
      start = 1'b0;
      chk({v.nm, " done pulse"}, 32'(i12.done), 0);
      tick();
      chk({v.nm, " idle busy"}, 32'(i12.busy), 0);
      chk({v.nm, " result held"}, 32'(i12.result),
          32'(v.exp12));
    end
  endtask

  initial begin
    int muls, cyc;
    tv[0] = '{"basic",
      {8'd1, 8'd8, 8'd5, 8'd2}, {8'd7, 8'd10, 8'd3, 8'd5},
      -1, 0, 1'b0, 112, 112, 21, 12};
    tv[1] = '{"wrap",
      {8'd15, 8'd15, 8'd15, 8'd15},
      {8'd15, 8'd15, 8'd15, 8'd15},
      -1, 0, 1'b0, 900, 132, 21, 12};
    tv[2] = '{"stall",
      {8'd1, 8'd8, 8'd5, 8'd2}, {8'd7, 8'd10, 8'd3, 8'd5},
      2, 3, 1'b0, 112, 112, 24, 12};
    tv[3] = '{"noise",
      {8'd1, 8'd8, 8'd5, 8'd2}, {8'd7, 8'd10, 8'd3, 8'd5},
      -1, 0, 1'b1, 112, 112, 21, 12};
`ifdef DOTP_ZERO_SKIP_EN
    tv[4] = '{"zero",
      {8'd1, 8'd8, 8'd5, 8'd0}, {8'd7, 8'd0, 8'd3, 8'd5},
      -1, 0, 1'b0, 22, 22, 15, 6};
`else
    tv[4] = '{"zero",
      {8'd1, 8'd8, 8'd5, 8'd0}, {8'd7, 8'd0, 8'd3, 8'd5},
      -1, 0, 1'b0, 22, 22, 21, 12};
`endif

    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(tv[i]);

    start = 1'b1;
    in_valid = 1'b1;
    in_a = 8'd3;
    in_b = 8'd4;
    tick();
    start = 1'b0;
    muls = 0;
    cyc = 0;
    while (muls < 3 && cyc < 100) begin
      if (i12.dp_load == 4'b1000) muls++;
      if (muls < 3) begin
        tick();
        cyc++;
      end
    end
    chk("midrun reached MUL", 32'(muls), 3);
    chk("midrun busy before rst", 32'(i12.busy), 1);
    rst = 1'b1;
    #1;
    chk_zero("midrun rst");
    tick();
    rst = 1'b0;
    tick();
    chk("post rst idle", 32'(i12.busy), 0);
    run_vec(tv[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
